// File: rtl/skew_inbuf_pkg.sv
// Shared limits, bubble constant and sizing helper for the skewed input buffer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package skew_inbuf_pkg;

  // Largest array edge and FIFO depth the buffer is built for.
  localparam int MAX_LANES = 32;
  localparam int MAX_DEPTH = 256;

  // Value injected into the skew chains on a read from an empty FIFO.
  localparam bit BUBBLE = 1'b0;

  // Pointer width for a FIFO of the given depth (ceil(log2)).
  function automatic int clog2_depth(input int depth);
    int r;
    r = 0;
    while ((1 << r) < depth) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/skew_lane.sv
// One lane's delay chain: STAGES registers, the last one drives the lane output.
// Latency: a word reaches dout after STAGES shifts (shifts, not clock cycles).
// Backpressure: none; the chain holds its contents whenever shift is low.
module skew_lane #(
  parameter int WORDLEN = 8,
  parameter int STAGES  = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               shift,
  input  logic [WORDLEN-1:0] din,
  input  logic               vin,
  output logic [WORDLEN-1:0] dout,
  output logic               vout
);

  logic [WORDLEN-1:0] dat [STAGES];
  logic [STAGES-1:0]  vld;

  // Shift data and valid together on each read; clear everything on reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < STAGES; k++) dat[k] <= '0;
      vld <= '0;
    end else if (shift) begin
      dat[0] <= din;
      vld[0] <= vin;
      for (int k = 1; k < STAGES; k++) begin
        dat[k] <= dat[k-1];
        vld[k] <= vld[k-1];
      end
    end
  end

  assign dout = dat[STAGES-1];
  assign vout = vld[STAGES-1];

endmodule

// File: rtl/skew_inbuf.sv
// Row FIFO feeding the systolic array edge; lane i of each popped row is delayed by i reads.
// Latency: write visible to read one edge later; lane i shows a popped word after i further reads.
// Backpressure: full drops writes unless a read frees a slot; optional sticky ovf via SKEW_INBUF_ERR_EN.
module skew_inbuf
  import skew_inbuf_pkg::*;
#(
  parameter int WORDLEN = 8,
  parameter int DEPTH   = 16,
  parameter int NLANES  = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         wr_en,
  input  logic [NLANES*WORDLEN-1:0]    wr_data,
  input  logic                         rd_en,
  output logic [NLANES*WORDLEN-1:0]    rd_data,
  output logic [NLANES-1:0]            rd_valid,
  output logic                         full,
  output logic                         empty,
  output logic [clog2_depth(DEPTH):0]  count
`ifdef SKEW_INBUF_ERR_EN
  ,
  output logic                         ovf
`endif
);

  localparam int AW = clog2_depth(DEPTH);
  localparam int RW = NLANES * WORDLEN;

  // Reject unsupported configurations at elaboration.
  if (NLANES < 1 || NLANES > MAX_LANES) begin : g_bad_lanes
    $error("skew_inbuf: NLANES out of range");
  end
  if (DEPTH < 2 || DEPTH > MAX_DEPTH || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("skew_inbuf: DEPTH must be a power of two in 2..256");
  end

  logic [RW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_nxt;
  logic          do_wr, do_rd;
  logic [RW-1:0] inject;

  // A read pops only when data is present; a write is taken unless full with no read.
  // When empty, a simultaneous write is stored but the read stays a bubble (no fall-through).
  always_comb begin
    do_rd     = rd_en && !empty;
    do_wr     = wr_en && (!full || rd_en);
    count_nxt = count + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
    inject    = do_rd ? mem[rd_ptr] : {RW{BUBBLE}};
  end

  // Row storage; contents need no reset, and writes are blocked while in reset.
  always_ff @(posedge clk) begin
    if (rstn && do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and registered flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == (AW+1)'(DEPTH));
    end
  end

`ifdef SKEW_INBUF_ERR_EN
  // Sticky overflow: a write arrived while full and nothing was read.
  always_ff @(posedge clk) begin
    if (!rstn) ovf <= 1'b0;
    else if (wr_en && full && !rd_en) ovf <= 1'b1;
  end
`endif

  // Lane i gets i+1 registers so it trails lane 0 by i reads.
  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    skew_lane #(
      .WORDLEN (WORDLEN),
      .STAGES  (i + 1)
    ) u_lane (
      .clk   (clk),
      .rstn  (rstn),
      .shift (rd_en),
      .din   (inject[i*WORDLEN +: WORDLEN]),
      .vin   (do_rd),
      .dout  (rd_data[i*WORDLEN +: WORDLEN]),
      .vout  (rd_valid[i])
    );
  end

endmodule

// File: tb/tb_skew_inbuf.sv
// Directed plus randomized checks of skew_inbuf against a queue-based reference model.
// Latency: each step drives on the falling edge and checks on the next falling edge.
// Backpressure: the model drops writes when full without a read, as the design does.
module tb_skew_inbuf;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int L  = 4;
  localparam int CW = 5;

  logic           clk = 1'b0;
  logic           rstn;
  logic           wr_en;
  logic           rd_en;
  logic [L*W-1:0] wr_data;
  logic [L*W-1:0] rd_data;
  logic [L-1:0]   rd_valid;
  logic           full;
  logic           empty;
  logic [CW-1:0]  count;
`ifdef SKEW_INBUF_ERR_EN
  logic           ovf;
`endif

  always #5 clk = ~clk;

  skew_inbuf #(.WORDLEN(W), .DEPTH(D), .NLANES(L)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .full     (full),
    .empty    (empty),
    .count    (count)
`ifdef SKEW_INBUF_ERR_EN
    ,
    .ovf      (ovf)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference model: FIFO contents, history of the last L reads, sticky overflow.
  logic [L*W-1:0] q    [$];
  logic [L*W-1:0] hrow [$];
  bit             hval [$];
  bit             m_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    hrow.delete();
    hval.delete();
    m_ovf = 1'b0;
  endtask

  // Lane i after the latest read shows the row popped i reads ago.
  task automatic check_all(input string tag);
    logic [L*W-1:0] ed;
    logic [L-1:0]   ev;
    int             idx;
    ed = '0;
    ev = '0;
    for (int i = 0; i < L; i++) begin
      idx = hrow.size() - 1 - i;
      if (idx >= 0) begin
        ed[i*W +: W] = hrow[idx][i*W +: W];
        ev[i]        = hval[idx];
      end
    end
    chk({tag, "_data"},  64'(rd_data),  64'(ed));
    chk({tag, "_valid"}, 64'(rd_valid), 64'(ev));
    chk({tag, "_count"}, 64'(count),    64'(q.size()));
    chk({tag, "_empty"}, 64'(empty),    64'(q.size() == 0));
    chk({tag, "_full"},  64'(full),     64'(q.size() == D));
`ifdef SKEW_INBUF_ERR_EN
    chk({tag, "_ovf"},   64'(ovf),      64'(m_ovf));
`endif
  endtask

  // One operation cycle: drive at negedge, update the model at posedge, check at next negedge.
  task automatic step(input bit w, input bit r, input logic [L*W-1:0] d, input string tag);
    int             sz;
    logic [L*W-1:0] row;
    bit             popped;
    rstn    = 1'b1;
    wr_en   = w;
    rd_en   = r;
    wr_data = d;
    @(posedge clk);
    sz     = q.size();
    row    = '0;
    popped = 1'b0;
    if (w && sz == D && !r) m_ovf = 1'b1;
    if (r && sz > 0) begin
      row    = q.pop_front();
      popped = 1'b1;
    end
    if (w && (sz < D || r)) q.push_back(d);
    if (r) begin
      hrow.push_back(row);
      hval.push_back(popped);
      if (hrow.size() > L) begin
        void'(hrow.pop_front());
        void'(hval.pop_front());
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_all(tag);
  endtask

  // Hold reset for n edges with random activity on the other inputs.
  task automatic do_reset(input int n, input string tag);
    rstn    = 1'b0;
    wr_en   = 1'b1;
    rd_en   = 1'($urandom);
    wr_data = L*W'($urandom);
    repeat (n) @(posedge clk);
    model_reset();
    @(negedge clk);
    rstn  = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_all(tag);
  endtask

  function automatic logic [L*W-1:0] rnd_row();
    return L*W'($urandom);
  endfunction

  initial begin
    logic [7:0]     b;
    logic [L*W-1:0] row;
    int             sz;
    int             op;

    rstn    = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    model_reset();
    @(negedge clk);

    // Reset state, with wr_en asserted to show it is ignored.
    do_reset(2, "reset");
    chk("reset_count_const", 64'(count), 64'd0);
    chk("reset_empty_const", 64'(empty), 64'd1);

    // Skew pattern: rows with lane words 0xA0+r, then seven reads.
    for (int r = 0; r < 4; r++) begin
      b   = 8'hA0 + 8'(r);
      row = {L{b}};
      step(1'b1, 1'b0, row, "skew_wr");
    end
    for (int k = 0; k < 7; k++) begin
      step(1'b0, 1'b1, '0, "skew_rd");
      if (k == 0) begin
        chk("skew_k0_data",  64'(rd_data),  64'h000000A0);
        chk("skew_k0_valid", 64'(rd_valid), 64'h1);
      end
      if (k == 3) begin
        chk("skew_k3_data",  64'(rd_data),  64'hA0A1A2A3);
        chk("skew_k3_valid", 64'(rd_valid), 64'hF);
      end
      if (k == 6) begin
        chk("skew_k6_data",  64'(rd_data),  64'hA3000000);
        chk("skew_k6_valid", 64'(rd_valid), 64'h8);
      end
    end

    // Fill to full, then an overflowing write, then drain in order.
    do_reset(1, "fill_rst");
    for (int n = 0; n < D; n++) step(1'b1, 1'b0, rnd_row(), "fill_wr");
    chk("fill_full_const",  64'(full),  64'd1);
    chk("fill_count_const", 64'(count), 64'd16);
    step(1'b1, 1'b0, rnd_row(), "ovf_wr");
    chk("ovf_count_const", 64'(count), 64'd16);
`ifdef SKEW_INBUF_ERR_EN
    chk("ovf_set_const", 64'(ovf), 64'd1);
`endif
    for (int n = 0; n < D + L - 1; n++) step(1'b0, 1'b1, '0, "drain_rd");

    // Simultaneous read and write while full, then while empty.
    do_reset(1, "rw_rst");
    for (int n = 0; n < D; n++) step(1'b1, 1'b0, rnd_row(), "rwfill_wr");
    step(1'b1, 1'b1, rnd_row(), "rw_full");
    chk("rw_full_count_const", 64'(count), 64'd16);
`ifdef SKEW_INBUF_ERR_EN
    chk("rw_full_ovf_const", 64'(ovf), 64'd0);
`endif
    for (int n = 0; n < D + L - 1; n++) step(1'b0, 1'b1, '0, "rwdrain_rd");
    step(1'b1, 1'b1, rnd_row(), "rw_empty");
    chk("rw_empty_valid0_const", 64'(rd_valid[0]), 64'd0);
    chk("rw_empty_count_const",  64'(count),       64'd1);

    // Randomized interleaving across pointer wrap with occupancy 3..12.
    while (q.size() < 3) step(1'b1, 1'b0, rnd_row(), "wrap_pre");
    for (int n = 0; n < 40; n++) begin
      sz = q.size();
      if (sz <= 3)       op = int'($urandom_range(0, 1)) * 2;
      else if (sz >= 12) op = 1;
      else               op = int'($urandom_range(0, 2));
      case (op)
        0:       step(1'b1, 1'b0, rnd_row(), "wrap_wr");
        1:       step(1'b0, 1'b1, '0,        "wrap_rd");
        default: step(1'b1, 1'b1, rnd_row(), "wrap_rw");
      endcase
    end

    // Mid-stream reset with five rows stored and a partly filled skew.
    do_reset(1, "mid_pre");
    for (int n = 0; n < 7; n++) step(1'b1, 1'b0, rnd_row(), "mid_wr");
    for (int n = 0; n < 2; n++) step(1'b0, 1'b1, '0, "mid_rd");
    chk("mid_count5_const", 64'(count), 64'd5);
    do_reset(1, "mid_rst");
    chk("mid_rst_data_const",  64'(rd_data),  64'd0);
    chk("mid_rst_valid_const", 64'(rd_valid), 64'd0);
    for (int n = 0; n < 3; n++) begin
      step(1'b0, 1'b1, '0, "mid_bubble");
      chk("mid_bubble_valid_const", 64'(rd_valid), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
